// File: rtl/vector_add_arbiter_if.sv
// Bundle of every non-clock, non-reset signal of vector_add_arbiter.
//   Requester side : req_a/req_b (one operand slot per requester), req_valid/req_ready,
//                    resp_result (shared), resp_valid/resp_ready (per requester), resp_error.
//   Adder side     : add_a/add_b + valids, add_a_ready/add_b_ready,
//                    add_result/add_result_valid/add_error, add_result_ready.
//   Status         : busy, grant_id.
// Modport slave is the arbiter's view; modport master is the surrounding system's view.
interface vector_add_arbiter_if #(
    parameter int NUM_REQ           = 2,
    parameter int VECTOR_LEN        = 5,
    parameter int A_CELL_WIDTH      = 8,
    parameter int B_CELL_WIDTH      = 8,
    parameter int RESULT_CELL_WIDTH = 8
);
    localparam int GRANT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int A_VEC_W = VECTOR_LEN * A_CELL_WIDTH;
    localparam int B_VEC_W = VECTOR_LEN * B_CELL_WIDTH;
    localparam int R_VEC_W = VECTOR_LEN * RESULT_CELL_WIDTH;

    logic [NUM_REQ*A_VEC_W-1:0] req_a;
    logic [NUM_REQ*B_VEC_W-1:0] req_b;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;

    logic [R_VEC_W-1:0]         resp_result;
    logic [NUM_REQ-1:0]         resp_valid;
    logic [NUM_REQ-1:0]         resp_ready;
    logic                       resp_error;

    logic [A_VEC_W-1:0]         add_a;
    logic [B_VEC_W-1:0]         add_b;
    logic                       add_a_valid;
    logic                       add_b_valid;
    logic                       add_a_ready;
    logic                       add_b_ready;
    logic [R_VEC_W-1:0]         add_result;
    logic                       add_result_valid;
    logic                       add_result_ready;
    logic                       add_error;

    logic                       busy;
    logic [GRANT_W-1:0]         grant_id;

    modport slave (
        input  req_a, req_b, req_valid, resp_ready,
        input  add_a_ready, add_b_ready, add_result, add_result_valid, add_error,
        output req_ready, resp_result, resp_valid, resp_error,
        output add_a, add_b, add_a_valid, add_b_valid, add_result_ready,
        output busy, grant_id
    );

    modport master (
        output req_a, req_b, req_valid, resp_ready,
        output add_a_ready, add_b_ready, add_result, add_result_valid, add_error,
        input  req_ready, resp_result, resp_valid, resp_error,
        input  add_a, add_b, add_a_valid, add_b_valid, add_result_ready,
        input  busy, grant_id
    );
endinterface

// File: rtl/vector_add_arbiter.sv
// Round-robin arbiter letting NUM_REQ requesters share one vector_add instance.
// One transaction is in flight at a time: IDLE picks a requester and captures its
// operands, ISSUE hands them to the adder, WAIT collects the result, RESP presents it
// to the granted requester until it is taken.
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset
//   bus  - vector_add_arbiter_if.slave: requester handshakes, adder handshakes,
//          busy (state != IDLE) and grant_id (requester currently served)
module vector_add_arbiter #(
    parameter int NUM_REQ           = 2,
    parameter int VECTOR_LEN        = 5,
    parameter int A_CELL_WIDTH      = 8,
    parameter int B_CELL_WIDTH      = 8,
    parameter int RESULT_CELL_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    vector_add_arbiter_if.slave   bus
);
    localparam int GRANT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int A_VEC_W = VECTOR_LEN * A_CELL_WIDTH;
    localparam int B_VEC_W = VECTOR_LEN * B_CELL_WIDTH;
    localparam int R_VEC_W = VECTOR_LEN * RESULT_CELL_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t               state_q, state_d;
    logic [GRANT_W-1:0]   last_grant_q, last_grant_d;
    logic [GRANT_W-1:0]   grant_id_q, grant_id_d;
    logic [A_VEC_W-1:0]   op_a_q, op_a_d;
    logic [B_VEC_W-1:0]   op_b_q, op_b_d;
    logic [R_VEC_W-1:0]   resp_result_q, resp_result_d;
    logic                 resp_error_q, resp_error_d;

    // Round-robin search results
    logic                 found;
    logic [GRANT_W-1:0]   sel;
    logic [GRANT_W-1:0]   cand;
    int unsigned          rr_idx;

    // Combinational handshake outputs
    logic [NUM_REQ-1:0]   req_ready_c;
    logic [NUM_REQ-1:0]   resp_valid_c;
    logic                 add_a_valid_c;
    logic                 add_b_valid_c;
    logic                 add_result_ready_c;

    // Search starts one past the last served requester so each requester is
    // skipped at most NUM_REQ-1 times while others are pending.
    always_comb begin
        found  = 1'b0;
        sel    = '0;
        cand   = '0;
        rr_idx = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            rr_idx = (32'(last_grant_q) + i) % NUM_REQ;
            cand   = GRANT_W'(rr_idx);
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        state_d            = state_q;
        last_grant_d       = last_grant_q;
        grant_id_d         = grant_id_q;
        op_a_d             = op_a_q;
        op_b_d             = op_b_q;
        resp_result_d      = resp_result_q;
        resp_error_d       = resp_error_q;
        req_ready_c        = '0;
        resp_valid_c       = '0;
        add_a_valid_c      = 1'b0;
        add_b_valid_c      = 1'b0;
        add_result_ready_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    req_ready_c[sel] = 1'b1;
                    grant_id_d       = sel;
                    op_a_d           = bus.req_a[32'(sel)*A_VEC_W +: A_VEC_W];
                    op_b_d           = bus.req_b[32'(sel)*B_VEC_W +: B_VEC_W];
                    state_d          = ISSUE;
                end
            end
            ISSUE: begin
                add_a_valid_c = 1'b1;
                add_b_valid_c = 1'b1;
                if (bus.add_a_ready && bus.add_b_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                add_result_ready_c = bus.add_result_valid;
                if (bus.add_result_valid) begin
                    resp_result_d = bus.add_result;
                    resp_error_d  = bus.add_error;
                    state_d       = RESP;
                end
            end
            RESP: begin
                resp_valid_c[grant_id_q] = 1'b1;
                // Only the granted requester's resp_ready completes the response.
                if (bus.resp_ready[grant_id_q]) begin
                    last_grant_d = grant_id_q;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset is synchronous, so state may still be stale during the first
        // reset cycle; force every handshake output low while rst is asserted.
        if (rst) begin
            req_ready_c        = '0;
            resp_valid_c       = '0;
            add_a_valid_c      = 1'b0;
            add_b_valid_c      = 1'b0;
            add_result_ready_c = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            last_grant_q  <= GRANT_W'(NUM_REQ - 1);
            grant_id_q    <= '0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            resp_result_q <= '0;
            resp_error_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_id_q    <= grant_id_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            resp_result_q <= resp_result_d;
            resp_error_q  <= resp_error_d;
        end
    end

    assign bus.req_ready        = req_ready_c;
    assign bus.resp_valid       = resp_valid_c;
    assign bus.resp_result      = resp_result_q;
    assign bus.resp_error       = resp_error_q;
    // Operand registers feed the adder directly so they stay stable through WAIT.
    assign bus.add_a            = op_a_q;
    assign bus.add_b            = op_b_q;
    assign bus.add_a_valid      = add_a_valid_c;
    assign bus.add_b_valid      = add_b_valid_c;
    assign bus.add_result_ready = add_result_ready_c;
    assign bus.busy             = (state_q != IDLE);
    assign bus.grant_id         = grant_id_q;

endmodule

// File: tb/tb_vector_add_arbiter.sv
// Directed bench for vector_add_arbiter with a behavioural vector adder
// (3-cycle latency, wrapping signed add, error on any signed cell overflow).
module tb_vector_add_arbiter;
    localparam int NR = 2;
    localparam int VL = 5;
    localparam int CW = 8;
    localparam int VW = VL * CW;
    localparam int ADD_LAT = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vector_add_arbiter_if #(
        .NUM_REQ(NR), .VECTOR_LEN(VL), .A_CELL_WIDTH(CW),
        .B_CELL_WIDTH(CW), .RESULT_CELL_WIDTH(CW)
    ) bus ();

    vector_add_arbiter #(
        .NUM_REQ(NR), .VECTOR_LEN(VL), .A_CELL_WIDTH(CW),
        .B_CELL_WIDTH(CW), .RESULT_CELL_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int            id;
        logic [VW-1:0] res;
        logic          err;
    } exp_t;
    exp_t sb[$];

    int stall_left  = 0;
    int model_phase = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] pack5(input int c0, input int c1, input int c2,
                                             input int c3, input int c4);
        logic [VW-1:0] v;
        v[7:0]   = c0[7:0];
        v[15:8]  = c1[7:0];
        v[23:16] = c2[7:0];
        v[31:24] = c3[7:0];
        v[39:32] = c4[7:0];
        return v;
    endfunction

    function automatic void add_model(input logic [VW-1:0] a, input logic [VW-1:0] b,
                                      output logic [VW-1:0] r, output logic e);
        logic [CW:0] s;
        r = '0;
        e = 1'b0;
        for (int i = 0; i < VL; i++) begin
            s = {a[i*CW+CW-1], a[i*CW +: CW]} + {b[i*CW+CW-1], b[i*CW +: CW]};
            r[i*CW +: CW] = s[CW-1:0];
            if (s[CW] != s[CW-1]) e = 1'b1;
        end
    endfunction

    // Behavioural shared adder
    initial begin
        logic [VW-1:0] lat_a, lat_b, r;
        logic e;
        int cnt;
        cnt = 0;
        lat_a = '0;
        lat_b = '0;
        bus.add_a_ready      = 1'b0;
        bus.add_b_ready      = 1'b0;
        bus.add_result_valid = 1'b0;
        bus.add_result       = '0;
        bus.add_error        = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                model_phase          = 0;
                bus.add_a_ready      = 1'b0;
                bus.add_b_ready      = 1'b0;
                bus.add_result_valid = 1'b0;
            end else begin
                case (model_phase)
                    0: begin
                        if (bus.add_a_valid && bus.add_b_valid) begin
                            bus.add_b_ready = 1'b1;
                            if (stall_left > 0) begin
                                bus.add_a_ready = 1'b0;
                                stall_left--;
                            end else begin
                                bus.add_a_ready = 1'b1;
                                lat_a = bus.add_a;
                                lat_b = bus.add_b;
                                cnt = ADD_LAT;
                                model_phase = 1;
                            end
                        end else begin
                            bus.add_a_ready = 1'b0;
                            bus.add_b_ready = 1'b0;
                        end
                    end
                    1: begin
                        bus.add_a_ready = 1'b0;
                        bus.add_b_ready = 1'b0;
                        check("add_a_held", 64'(bus.add_a), 64'(lat_a));
                        check("add_b_held", 64'(bus.add_b), 64'(lat_b));
                        check("add_result_ready_low", 64'(bus.add_result_ready), 64'(0));
                        cnt--;
                        if (cnt == 0) begin
                            add_model(lat_a, lat_b, r, e);
                            bus.add_result       = r;
                            bus.add_error        = e;
                            bus.add_result_valid = 1'b1;
                            model_phase = 2;
                            #1;
                            check("add_result_ready", 64'(bus.add_result_ready), 64'(1));
                        end
                    end
                    default: begin
                        // Junk on the bus once valid drops must never be captured.
                        bus.add_result_valid = 1'b0;
                        bus.add_result       = '1;
                        bus.add_error        = 1'b1;
                        model_phase = 0;
                    end
                endcase
            end
        end
    end

    task automatic push_exp(input int k);
        logic [VW-1:0] r;
        logic e;
        add_model(bus.req_a[k*VW +: VW], bus.req_b[k*VW +: VW], r, e);
        sb.push_back('{k, r, e});
    endtask

    task automatic do_accept(input int exp_id);
        int n;
        n = 0;
        #1;
        while (bus.req_ready == '0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("accept_seen", 64'(n < 20), 64'(1));
        check("req_ready_onehot", 64'(bus.req_ready), 64'(1) << exp_id);
        check("busy_in_idle", 64'(bus.busy), 64'(0));
        @(posedge clk);
        @(negedge clk);
        check("grant_id", 64'(bus.grant_id), 64'(exp_id));
        check("busy_in_issue", 64'(bus.busy), 64'(1));
        check("issue_valids", 64'({bus.add_a_valid, bus.add_b_valid}), 64'(3));
        check("req_ready_in_issue", 64'(bus.req_ready), 64'(0));
    endtask

    task automatic wait_resp(output logic [VW-1:0] got);
        exp_t e;
        int n;
        n = 0;
        while (bus.resp_valid == '0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("resp_latency", 64'(n), 64'(ADD_LAT + 1));
        if (sb.size() > 0) e = sb.pop_front();
        else e = '{-1, '0, 1'b0};
        check("resp_valid_onehot", 64'(bus.resp_valid), 64'(1) << e.id);
        check("resp_result", 64'(bus.resp_result), 64'(e.res));
        check("resp_error", 64'(bus.resp_error), 64'(e.err));
        check("resp_grant_id", 64'(bus.grant_id), 64'(e.id));
        check("req_ready_in_resp", 64'(bus.req_ready), 64'(0));
        got = bus.resp_result;
    endtask

    task automatic complete_resp(input int id);
        bus.resp_ready[id] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.resp_ready = '0;
        check("resp_valid_drop", 64'(bus.resp_valid), 64'(0));
        check("idle_after_resp", 64'(bus.busy), 64'(0));
    endtask

    task automatic txn(input int k, input logic [VW-1:0] a, input logic [VW-1:0] b);
        logic [VW-1:0] got;
        bus.req_a[k*VW +: VW] = a;
        bus.req_b[k*VW +: VW] = b;
        bus.req_valid[k] = 1'b1;
        push_exp(k);
        do_accept(k);
        bus.req_valid[k] = 1'b0;
        wait_resp(got);
        complete_resp(k);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VW-1:0] got, held;
        int n;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_valid  = '0;
        bus.resp_ready = '0;

        // Reset with requests pending: all handshake outputs must stay low
        rst = 1'b1;
        bus.req_valid  = 2'b11;
        bus.resp_ready = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(bus.req_ready), 64'(0));
        check("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
        check("rst_add_valids", 64'({bus.add_a_valid, bus.add_b_valid}), 64'(0));
        check("rst_add_result_ready", 64'(bus.add_result_ready), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_grant_id", 64'(bus.grant_id), 64'(0));
        check("rst_resp_result", 64'(bus.resp_result), 64'(0));
        check("rst_resp_error", 64'(bus.resp_error), 64'(0));
        check("rst_add_a", 64'(bus.add_a), 64'(0));
        check("rst_add_b", 64'(bus.add_b), 64'(0));
        bus.req_valid  = '0;
        bus.resp_ready = '0;
        rst = 1'b0;
        @(negedge clk);

        // Single request from requester 0
        txn(0, pack5(1, 2, 3, 4, 5), pack5(10, 10, 10, 10, 10));
        check("single_result_value", 64'(bus.resp_result), 64'(pack5(11, 12, 13, 14, 15)));
        check("single_result_error", 64'(bus.resp_error), 64'(0));

        // Contention after reset: order 0,1,0,1
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.req_a[0*VW +: VW] = pack5(20, 30, 40, 50, 60);
        bus.req_b[0*VW +: VW] = pack5(1, 1, 1, 1, 1);
        bus.req_a[1*VW +: VW] = pack5(100, 90, 80, 70, 60);
        bus.req_b[1*VW +: VW] = pack5(-3, -3, -3, -3, -3);
        bus.req_valid = 2'b11;
        for (int t = 0; t < 4; t++) begin
            push_exp(t % 2);
            do_accept(t % 2);
            wait_resp(got);
            complete_resp(t % 2);
        end
        bus.req_valid = '0;

        // Overflow from requester 1, then a clean transaction clears the flag
        txn(1, pack5(127, 0, 0, 0, 0), pack5(1, 0, 0, 0, 0));
        txn(0, pack5(5, 6, 7, 8, 9), pack5(1, 1, 1, 1, 1));

        // Backpressure: response held 10 cycles with a competing request pending
        bus.req_a[1*VW +: VW] = pack5(33, 44, 55, 66, 77);
        bus.req_b[1*VW +: VW] = pack5(2, 2, 2, 2, 2);
        bus.req_a[0*VW +: VW] = pack5(9, 8, 7, 6, 5);
        bus.req_b[0*VW +: VW] = pack5(4, 4, 4, 4, 4);
        bus.req_valid[1] = 1'b1;
        push_exp(1);
        do_accept(1);
        bus.req_valid[1] = 1'b0;
        bus.req_valid[0] = 1'b1;
        wait_resp(held);
        bus.resp_ready[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_resp_valid", 64'(bus.resp_valid), 64'(2));
            check("bp_resp_result", 64'(bus.resp_result), 64'(held));
            check("bp_req_ready", 64'(bus.req_ready), 64'(0));
        end
        complete_resp(1);
        push_exp(0);
        do_accept(0);
        bus.req_valid[0] = 1'b0;
        wait_resp(got);
        complete_resp(0);

        // Adder stalls add_a_ready for 5 cycles in ISSUE
        stall_left = 5;
        bus.req_a[0*VW +: VW] = pack5(-10, -20, 30, 40, 50);
        bus.req_b[0*VW +: VW] = pack5(5, 5, 5, 5, 5);
        bus.req_valid[0] = 1'b1;
        push_exp(0);
        do_accept(0);
        bus.req_valid[0] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check("stall_valids", 64'({bus.add_a_valid, bus.add_b_valid}), 64'(3));
            check("stall_add_a", 64'(bus.add_a), 64'(pack5(-10, -20, 30, 40, 50)));
            check("stall_add_b", 64'(bus.add_b), 64'(pack5(5, 5, 5, 5, 5)));
            @(negedge clk);
        end
        wait_resp(got);
        complete_resp(0);

        // Reset while in WAIT drops the transaction and restores requester 0 priority
        bus.req_a[1*VW +: VW] = pack5(1, 1, 1, 1, 1);
        bus.req_b[1*VW +: VW] = pack5(1, 1, 1, 1, 1);
        bus.req_valid[1] = 1'b1;
        push_exp(1);
        do_accept(1);
        bus.req_valid[1] = 1'b0;
        n = 0;
        while (model_phase != 1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("reached_wait", 64'(model_phase), 64'(1));
        rst = 1'b1;
        bus.req_valid = 2'b11;
        @(posedge clk);
        @(negedge clk);
        check("rst_wait_busy", 64'(bus.busy), 64'(0));
        check("rst_wait_resp_valid", 64'(bus.resp_valid), 64'(0));
        check("rst_wait_req_ready", 64'(bus.req_ready), 64'(0));
        rst = 1'b0;
        void'(sb.pop_back());
        push_exp(0);
        do_accept(0);
        bus.req_valid = '0;
        wait_resp(got);
        complete_resp(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vector_add_arbiter.md
VECTOR_ADD_ARBITER -- requirements
Module: vector_add_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 2, giving the number of requesters sharing one vector_add instance.
REQ-002 The block SHALL have parameters VECTOR_LEN 5, A_CELL_WIDTH 8, B_CELL_WIDTH 8 and RESULT_CELL_WIDTH 8, matching the shared adder.
REQ-003 The block SHALL have port clk, input, 1 bit, the clock.
REQ-004 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-005 The block SHALL have port req_a, input, NUM_REQ*VECTOR_LEN*A_CELL_WIDTH bits, holding the operand A vector of each requester; slot k is requester k.
REQ-006 The block SHALL have port req_b, input, NUM_REQ*VECTOR_LEN*B_CELL_WIDTH bits, holding the operand B vector of each requester.
REQ-007 The block SHALL have ports req_valid (input) and req_ready (output), NUM_REQ bits each, one request handshake per requester.
REQ-008 The block SHALL have port resp_result, output, VECTOR_LEN*RESULT_CELL_WIDTH bits, a result bus shared by all requesters.
REQ-009 The block SHALL have ports resp_valid (output) and resp_ready (input), NUM_REQ bits each, one response handshake per requester.
REQ-010 The block SHALL have port resp_error, output, 1 bit, the overflow flag of the current response.
REQ-011 The block SHALL have adder-side outputs add_a, add_b, add_a_valid, add_b_valid and add_result_ready, with add_a and add_b at vector width.
REQ-012 The block SHALL have adder-side inputs add_a_ready, add_b_ready, add_result (vector width), add_result_valid and add_error.
REQ-013 The block SHALL have outputs busy (1 bit) and grant_id (max(1,clog2(NUM_REQ)) bits).

Function
REQ-014 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP, with busy = (state != IDLE).
REQ-015 In IDLE with any req_valid high, the block SHALL select a requester round-robin, starting the search at last_grant+1 and wrapping modulo NUM_REQ.
REQ-016 On that same IDLE edge, the block SHALL latch the selected requester into grant_id, latch its A/B slices into operand registers, and go to ISSUE.
REQ-017 req_ready[g] SHALL be high only in IDLE, combinationally, for the selected requester g, so acceptance is a one-cycle handshake; all other req_ready bits SHALL be 0.
REQ-018 In ISSUE, add_a_valid and add_b_valid SHALL be 1; on the edge where add_a_ready && add_b_ready, the FSM SHALL go to WAIT.
REQ-019 add_a and add_b SHALL be driven from the operand registers and held stable from ISSUE through WAIT, because the adder reads them across its calculation cycles.
REQ-020 In WAIT, add_result_ready SHALL equal add_result_valid.
REQ-021 On the WAIT edge where add_result_valid is high, the block SHALL latch add_result into resp_result and add_error into resp_error, then go to RESP; add_result_ready SHALL be 0 in every other state.
REQ-022 In RESP, resp_valid[grant_id] SHALL be 1 and all other resp_valid bits 0.
REQ-023 On the RESP edge where resp_ready[grant_id] is high, the block SHALL set last_grant to grant_id and go to IDLE; resp_ready on other bits SHALL be ignored.
REQ-024 Only one transaction SHALL be in flight at a time; req_valid changes outside IDLE SHALL have no effect.
REQ-025 Latency SHALL be exactly 1 cycle from acceptance to ISSUE, plus the adder's latency, plus 1 cycle to RESP.
REQ-026 No new request SHALL be accepted in the cycle resp completes; IDLE always lasts at least 1 cycle.
REQ-027 The block SHALL perform no arithmetic; resp_error SHALL be passed through per transaction and is not sticky across transactions.

Reset
REQ-028 On rst, the block SHALL set state to IDLE, last_grant to NUM_REQ-1 (requester 0 first), and grant_id, the operand registers, resp_result and resp_error to 0.
REQ-029 While rst is high, all valid/ready outputs SHALL be 0.
REQ-030 A reset mid-transaction SHALL drop the transaction without producing a response; the shared adder is reset by the same rst.

Verification
REQ-031 Single request: requester 0 sends A={1,2,3,4,5}, B={10,10,10,10,10} -> resp_valid[0], resp_result={11,12,13,14,15}, resp_error 0.
REQ-032 Contention: both requesters hold req_valid after reset -> grant order 0,1,0,1 over four transactions, and no requester is granted twice in a row.
REQ-033 Overflow: requester 1 sends cell 127+1 -> resp_error 1 for that response; the next clean transaction -> resp_error 0.
REQ-034 Backpressure: resp_ready held 0 for 10 cycles -> resp_valid stays high, resp_result stays stable, and no new req_ready occurs.
REQ-035 Stall: add_a_ready low for 5 cycles in ISSUE -> operands held and add valids high, then normal completion.
REQ-036 Reset in WAIT -> busy 0 the next cycle, no resp_valid, and requester 0 has priority afterward.
